uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, data bits per frame (5..9).
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port i_rx  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have port o_data  output  DATA_BITS  last received data word, LSB = first data bit on the line.
REQ-010 SHALL have port o_valid  output  1  one-cycle pulse when a frame completes; o_data and error flags are qualified by it.
REQ-011 SHALL have port o_parity_err  output  1  parity mismatch on the frame reported with o_valid.
REQ-012 SHALL have port o_frame_err  output  1  a stop bit sampled low on the frame reported with o_valid.
REQ-013 SHALL have port o_busy  output  1  high from start-bit detection until return to IDLE.

Function
REQ-014 SHALL pass i_rx through a two-flop synchronizer before any use; synchronizer flops reset to 1.
REQ-015 SHALL generate a 16x oversample tick every DIV = CLK_FREQ/(BAUD_RATE*16) clocks (integer floor; 27 at defaults); divider counter wraps DIV-1 -> 0 and free-runs only while not IDLE, restarting at 0 on start detection.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-017 IDLE: on synchronized i_rx low SHALL go to START, clear tick count, assert o_busy.
REQ-018 START: after 8 ticks SHALL resample; low -> DATA; high -> IDLE as glitch, no o_valid.
REQ-019 DATA: SHALL sample every 16 ticks (bit centre), shift LSB-first, after DATA_BITS samples go to PARITY if PARITY != 0 else STOP.
REQ-020 PARITY: SHALL sample one bit after 16 ticks; odd mode error when XOR(data, bit) = 0; even mode error when XOR(data, bit) = 1.
REQ-021 STOP: SHALL sample STOP_BITS bits at 16-tick spacing; any low sample sets frame error.
REQ-022 SHALL assert o_valid for exactly one clock on the cycle after the final stop-bit sample, with o_data, o_parity_err, o_frame_err updated on that same cycle.
REQ-023 o_data SHALL hold its value until the next o_valid; error flags SHALL be low whenever o_valid is low.
REQ-024 o_valid SHALL pulse for every completed frame including errored frames; glitch-rejected starts SHALL produce nothing.
REQ-025 After o_valid with frame error and line still low (break), SHALL enter WAIT_HIGH and stay until synchronized i_rx high, then IDLE; otherwise return directly to IDLE.
REQ-026 A falling edge during DATA/PARITY/STOP SHALL be ignored; new start detection only from IDLE.
REQ-027 o_busy SHALL deassert on the cycle the FSM enters IDLE.

Reset
REQ-028 On n_rst low SHALL immediately force state IDLE, counters 0, shift register 0, o_data 0, o_valid 0, o_parity_err 0, o_frame_err 0, o_busy 0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, receiver SHALL wait for the next high-to-low transition.

Verification (defaults unless stated; bit time 432 clocks)
REQ-030 Send 0xA5, 8N1 -> one o_valid pulse, o_data = 0xA5, both error flags 0, o_busy low after it.
REQ-031 Low glitch of 100 clocks on idle line -> no o_valid, o_busy returns low within 8 ticks (216 clocks) + 3.
REQ-032 Send 0x3C with stop bit driven low, then line high -> o_valid with o_frame_err = 1, o_data = 0x3C; next frame 0x55 received clean.
REQ-033 PARITY=2, send 0x07 with parity bit 0 -> o_parity_err = 1; same with parity bit 1 -> o_parity_err = 0.
REQ-034 Line held low 20 bit times -> single o_valid, o_data = 0x00, o_frame_err = 1, o_busy high until line returns high, no further pulses.
REQ-035 Back-to-back frames 0x01, 0xFF, 0x80 with no idle gap, plus n_rst pulsed mid-way through a fourth frame -> three correct o_valid pulses, all outputs 0 during reset, no pulse for the fourth frame.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, configurable data/stop/parity framing,
// and break handling (waits for the line to return high after a stuck-low frame).
module uart_rx #(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 115200,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int PARITY    = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 i_rx,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam int BIT_W   = $clog2(DATA_BITS + 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic                 rx_meta_q, rx_sync_q;
  logic [1:0]           flush_q;
  logic                 armed_q;
  state_t               state_q, state_d;
  logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bit_q, par_bit_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 tick;
  logic                 par_xor;
  logic                 par_err;
  logic                 frame_bad;

  // Synchronizer plus an arming flag: after reset the line must be seen high
  // (through a flushed synchronizer) before a falling edge can start a frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      flush_q   <= 2'b00;
      armed_q   <= 1'b0;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      flush_q   <= {flush_q[0], 1'b1};
      armed_q   <= armed_q | (flush_q[1] & rx_sync_q);
    end
  end

  assign tick = (state_q != S_IDLE) && (div_cnt_q == DIV_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if ((state_q == S_IDLE) || tick) begin
      div_cnt_d = '0;
    end
  end

  assign par_xor   = (^shift_q) ^ par_bit_q;
  assign par_err   = (PARITY == 1) ? ~par_xor : ((PARITY == 2) ? par_xor : 1'b0);
  assign frame_bad = ferr_acc_q | ~rx_sync_q;

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    ferr_acc_d = ferr_acc_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = 1'b0;
    ferr_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (armed_q && !rx_sync_q) begin
          state_d    = S_START;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_bit_d  = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end

      S_START: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = '0;
            state_d    = rx_sync_q ? S_IDLE : S_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == DATA_LAST) begin
              bit_cnt_d = '0;
              state_d   = (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end

      S_PARITY: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            par_bit_d = rx_sync_q;
            state_d   = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            if (stop_cnt_q == STOP_LAST) begin
              valid_d = 1'b1;
              data_d  = shift_q;
              perr_d  = par_err;
              ferr_d  = frame_bad;
              // A low final stop sample means the line may be in break.
              state_d = rx_sync_q ? S_IDLE : S_WAIT_HIGH;
            end else begin
              stop_cnt_d = 1'b1;
              ferr_acc_d = frame_bad;
            end
          end
        end
      end

      S_WAIT_HIGH: begin
        if (rx_sync_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: an 8N1 instance and an 8E1 instance, each
// fed serial frames built from bit lists and checked against a frame queue.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT_CLKS = 432;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } frame_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       n_rst_p = 1'b0;
  logic       rx = 1'b1;
  logic       rx_p = 1'b1;
  logic [7:0] o_data, o_data_p;
  logic       o_valid, o_valid_p;
  logic       o_parity_err, o_parity_err_p;
  logic       o_frame_err, o_frame_err_p;
  logic       o_busy, o_busy_p;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  frame_t exp_q[$];
  frame_t exp_p_q[$];
  frame_t mon_f, mon_fp;

  always #10 clk = ~clk;

  uart_rx dut (
    .clk(clk), .n_rst(n_rst), .i_rx(rx),
    .o_data(o_data), .o_valid(o_valid), .o_parity_err(o_parity_err),
    .o_frame_err(o_frame_err), .o_busy(o_busy)
  );

  uart_rx #(.PARITY(2)) dut_p (
    .clk(clk), .n_rst(n_rst_p), .i_rx(rx_p),
    .o_data(o_data_p), .o_valid(o_valid_p), .o_parity_err(o_parity_err_p),
    .o_frame_err(o_frame_err_p), .o_busy(o_busy_p)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drives one frame (start, 8 data LSB first, optional parity, one stop, idle gap)
  // and records the frame the receiver is expected to report.
  task automatic send_frame(input bit on_p, input logic [7:0] data, input bit with_par,
                            input bit par_bit, input bit stop_val, input int gap_bits);
    logic   bits[$];
    frame_t f;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (with_par) bits.push_back(par_bit);
    bits.push_back(stop_val);
    for (int i = 0; i < gap_bits; i++) bits.push_back(1'b1);
    f.data = data;
    f.perr = with_par ? ((^data) ^ par_bit) : 1'b0;
    f.ferr = ~stop_val;
    if (on_p) exp_p_q.push_back(f);
    else exp_q.push_back(f);
    $display("send %s data=0x%02h par=%0d/%0d stop=%0d gap=%0d",
             on_p ? "8E1" : "8N1", data, with_par, par_bit, stop_val, gap_bits);
    foreach (bits[i]) begin
      if (on_p) rx_p = bits[i];
      else rx = bits[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (o_valid) begin
      check_eq("main_valid_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_f = exp_q.pop_front();
        $display("rx  8N1 data=0x%02h perr=%0d ferr=%0d", o_data, o_parity_err, o_frame_err);
        check_eq("main_data", 32'(o_data), 32'(mon_f.data));
        check_eq("main_perr", 32'(o_parity_err), 32'(mon_f.perr));
        check_eq("main_ferr", 32'(o_frame_err), 32'(mon_f.ferr));
      end
    end else if (n_rst && (cyc % 64 == 0)) begin
      check_eq("main_flags_idle", 32'({o_parity_err, o_frame_err}), 32'd0);
    end
  end

  always @(negedge clk) begin
    if (o_valid_p) begin
      check_eq("par_valid_expected", 32'(exp_p_q.size() != 0), 32'd1);
      if (exp_p_q.size() != 0) begin
        mon_fp = exp_p_q.pop_front();
        $display("rx  8E1 data=0x%02h perr=%0d ferr=%0d", o_data_p, o_parity_err_p, o_frame_err_p);
        check_eq("par_data", 32'(o_data_p), 32'(mon_fp.data));
        check_eq("par_perr", 32'(o_parity_err_p), 32'(mon_fp.perr));
        check_eq("par_ferr", 32'(o_frame_err_p), 32'(mon_fp.ferr));
      end
    end
  end

  initial begin
    logic [7:0] rd;
    bit         rs;
    repeat (5) @(negedge clk);
    check_eq("rst_valid", 32'(o_valid), 32'd0);
    check_eq("rst_data", 32'(o_data), 32'd0);
    check_eq("rst_flags", 32'({o_parity_err, o_frame_err}), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);
    check_eq("rst_busy_p", 32'(o_busy_p), 32'd0);
    n_rst = 1'b1;
    n_rst_p = 1'b1;
    repeat (5) @(negedge clk);

    fork
      begin
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1);
        check_eq("a5_drained", 32'(exp_q.size()), 32'd0);
        check_eq("a5_busy_low", 32'(o_busy), 32'd0);

        rx = 1'b0;
        repeat (50) @(negedge clk);
        check_eq("glitch_busy_high", 32'(o_busy), 32'd1);
        repeat (50) @(negedge clk);
        rx = 1'b1;
        repeat (130) @(negedge clk);
        check_eq("glitch_busy_low", 32'(o_busy), 32'd0);
        repeat (BIT_CLKS) @(negedge clk);

        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1);
        check_eq("badstop_drained", 32'(exp_q.size()), 32'd0);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1);
        check_eq("after_badstop_drained", 32'(exp_q.size()), 32'd0);

        exp_q.push_back('{data: 8'h00, perr: 1'b0, ferr: 1'b1});
        $display("send 8N1 break 20 bit times");
        rx = 1'b0;
        repeat (20 * BIT_CLKS) @(negedge clk);
        check_eq("break_busy_high", 32'(o_busy), 32'd1);
        check_eq("break_drained", 32'(exp_q.size()), 32'd0);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        check_eq("break_busy_low", 32'(o_busy), 32'd0);

        send_frame(1'b0, 8'h01, 1'b0, 1'b0, 1'b1, 0);
        send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 0);
        send_frame(1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 0);
        check_eq("b2b_drained", 32'(exp_q.size()), 32'd0);
        $display("send 8N1 data=0x00 with reset mid-frame (no frame expected)");
        rx = 1'b0;
        repeat (1000) @(negedge clk);
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("midrst_valid", 32'(o_valid), 32'd0);
        check_eq("midrst_data", 32'(o_data), 32'd0);
        check_eq("midrst_flags", 32'({o_parity_err, o_frame_err}), 32'd0);
        check_eq("midrst_busy", 32'(o_busy), 32'd0);
        repeat (20) @(negedge clk);
        n_rst = 1'b1;
        repeat (9 * BIT_CLKS - 1023) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check_eq("midrst_no_frame", 32'(exp_q.size()), 32'd0);
        check_eq("midrst_busy_after", 32'(o_busy), 32'd0);

        send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 1);
        check_eq("post_rst_drained", 32'(exp_q.size()), 32'd0);

        for (int k = 0; k < 3; k++) begin
          rd = 8'($urandom);
          rs = ($urandom_range(0, 3) != 0);
          send_frame(1'b0, rd, 1'b0, 1'b0, rs, 1);
          check_eq("rand_drained", 32'(exp_q.size()), 32'd0);
        end
      end

      begin
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, 1);
        check_eq("par0_drained", 32'(exp_p_q.size()), 32'd0);
        send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1, 1);
        check_eq("par1_drained", 32'(exp_p_q.size()), 32'd0);
        for (int k = 0; k < 3; k++) begin
          send_frame(1'b1, 8'($urandom), 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1);
          check_eq("par_rand_drained", 32'(exp_p_q.size()), 32'd0);
        end
        check_eq("par_busy_low", 32'(o_busy_p), 32'd0);
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
